// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF/IE registers on the CPU bus, rising-edge capture of the
// five request lines, fixed-priority selection and a request/acknowledge handshake to the CPU.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        I_CLOCK,
  input  logic        I_RESET_L,
  input  logic [15:0] I_ADDR,
  inout  wire  [7:0]  IO_DATA,
  input  logic        I_RE_L,
  input  logic        I_WE_L,
  input  logic        I_VBLANK_INTERRUPT,
  input  logic        I_LCDC_INTERRUPT,
  input  logic        I_TIMER_INTERRUPT,
  input  logic        I_SERIAL_INTERRUPT,
  input  logic        I_JOYPAD_INTERRUPT,
  input  logic        I_ACK,
  output logic        O_INTERRUPT,
  output logic [15:0] O_VECTOR
);

  typedef enum logic [1:0] {StIdle, StRequest, StService} state_e;

  state_e      state_q, state_d;
  logic [4:0]  prev_q;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic [4:0]  lines;
  logic [4:0]  edges;
  logic [4:0]  pending;
  logic [4:0]  ack_mask;
  logic [2:0]  sel;
  logic        wr_if, wr_ie;
  logic        rd_en;
  logic [7:0]  rd_data;

  assign lines   = {I_JOYPAD_INTERRUPT, I_SERIAL_INTERRUPT, I_TIMER_INTERRUPT,
                    I_LCDC_INTERRUPT, I_VBLANK_INTERRUPT};
  assign edges   = lines & ~prev_q;
  assign pending = if_q & ie_q[4:0];

  // Write wins over a concurrent read, so the bus is only driven when no write is active.
  assign wr_if = !I_WE_L && (I_ADDR == IF_ADDR);
  assign wr_ie = !I_WE_L && (I_ADDR == IE_ADDR);
  assign rd_en = !I_RE_L && I_WE_L && ((I_ADDR == IF_ADDR) || (I_ADDR == IE_ADDR));

  // Read mux; unused IF bits read back as ones.
  always_comb begin
    rd_data = 8'h00;
    if (I_ADDR == IF_ADDR) rd_data = {3'b111, if_q};
    else if (I_ADDR == IE_ADDR) rd_data = ie_q;
  end

  assign IO_DATA = rd_en ? rd_data : 8'bzzzz_zzzz;

  // Lowest set bit of pending has highest priority.
  always_comb begin
    sel = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) sel = 3'(i);
    end
  end

  // Handshake FSM; the ack mask is only produced on the accepting REQUEST cycle.
  always_comb begin
    state_d     = state_q;
    ack_mask    = 5'b00000;
    O_INTERRUPT = 1'b0;
    O_VECTOR    = 16'h0000;
    unique case (state_q)
      StIdle: begin
        if (pending != 5'b00000) state_d = StRequest;
      end
      StRequest: begin
        O_INTERRUPT = 1'b1;
        O_VECTOR    = 16'h0040 | {10'b0, sel, 3'b000};
        if (pending == 5'b00000) begin
          state_d = StIdle;
        end else if (I_ACK) begin
          state_d  = StService;
          ack_mask = 5'b00001 << sel;
        end
      end
      StService: begin
        if (!I_ACK) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // IF next value: bus write, then ack clear, then new edges on top.
  always_comb begin
    if_d = wr_if ? IO_DATA[4:0] : if_q;
    if_d = if_d & ~ack_mask;
    if_d = if_d | edges;
    ie_d = wr_ie ? IO_DATA : ie_q;
  end

  // State registers.
  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q <= StIdle;
      prev_q  <= 5'b00000;
      if_q    <= 5'b00000;
      ie_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      prev_q  <= lines;
      if_q    <= if_d;
      ie_q    <= ie_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: bus access, edge capture, priority and handshake.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [15:0] addr;
  logic        re_l, we_l;
  logic        vblank, lcdc, timer, serial, joypad;
  logic        ack;
  logic        irq;
  logic [15:0] vector;
  logic [7:0]  tb_data;
  logic        tb_drive;
  wire  [7:0]  data_bus;

  int errors = 0;
  int checks = 0;

  assign data_bus = tb_drive ? tb_data : 8'bzzzz_zzzz;

  // Undriven bus reads as zero so "not driven" is observable.
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (data_bus[g]);
  end

  always #5 clk = ~clk;

  interrupt_controller dut (
    .I_CLOCK            (clk),
    .I_RESET_L          (rst_l),
    .I_ADDR             (addr),
    .IO_DATA            (data_bus),
    .I_RE_L             (re_l),
    .I_WE_L             (we_l),
    .I_VBLANK_INTERRUPT (vblank),
    .I_LCDC_INTERRUPT   (lcdc),
    .I_TIMER_INTERRUPT  (timer),
    .I_SERIAL_INTERRUPT (serial),
    .I_JOYPAD_INTERRUPT (joypad),
    .I_ACK              (ack),
    .O_INTERRUPT        (irq),
    .O_VECTOR           (vector)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr     = a;
    tb_data  = d;
    tb_drive = 1'b1;
    we_l     = 1'b0;
    step();
    we_l     = 1'b1;
    tb_drive = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    tb_drive = 1'b0;
    addr     = a;
    re_l     = 1'b0;
    #1;
    check(tag, {8'h00, data_bus}, {8'h00, exp});
    re_l     = 1'b1;
    #1;
  endtask

  task automatic check_irq(input string tag, input logic exp_irq, input logic [15:0] exp_vec);
    check({tag, "_irq"}, {15'h0, irq}, {15'h0, exp_irq});
    check({tag, "_vec"}, vector, exp_vec);
  endtask

  initial begin
    rst_l = 1'b0; addr = 16'h0000; re_l = 1'b1; we_l = 1'b1;
    vblank = 0; lcdc = 0; timer = 0; serial = 0; joypad = 0; ack = 0;
    tb_data = 8'h00; tb_drive = 1'b0;

    // Reset state.
    #2;
    check_irq("rst", 1'b0, 16'h0000);
    bus_read("rst_if", 16'hFF0F, 8'hE0);
    bus_read("rst_ie", 16'hFFFF, 8'h00);
    step();
    rst_l = 1'b1;
    step();

    // Single timer request and ack.
    bus_write(16'hFFFF, 8'h04);
    timer = 1; step(); timer = 0;
    bus_read("t1_if_set", 16'hFF0F, 8'hE4);
    check_irq("t1_lat1", 1'b0, 16'h0000);
    step();
    check_irq("t1_req", 1'b1, 16'h0050);
    ack = 1; step(); ack = 0;
    bus_read("t1_if_clr", 16'hFF0F, 8'hE0);
    check_irq("t1_svc", 1'b0, 16'h0000);
    step();

    // Two sources at once: vblank first, then joypad.
    bus_write(16'hFFFF, 8'h1F);
    joypad = 1; vblank = 1; step(); joypad = 0; vblank = 0;
    step();
    check_irq("t2_vb", 1'b1, 16'h0040);
    ack = 1; step();
    check_irq("t2_svc", 1'b0, 16'h0000);
    ack = 0; step();
    check_irq("t2_idle", 1'b0, 16'h0000);
    step();
    check_irq("t2_jp", 1'b1, 16'h0060);
    bus_read("t2_if", 16'hFF0F, 8'hF0);
    ack = 1; step(); ack = 0; step();
    bus_read("t2_if_clr", 16'hFF0F, 8'hE0);

    // Masked serial, then enable it.
    bus_write(16'hFFFF, 8'h00);
    serial = 1; step(); serial = 0;
    bus_read("t3_if", 16'hFF0F, 8'hE8);
    step(); step();
    check_irq("t3_masked", 1'b0, 16'h0000);
    bus_write(16'hFFFF, 8'h08);
    check_irq("t3_ie_wr", 1'b0, 16'h0000);
    step();
    check_irq("t3_req", 1'b1, 16'h0058);

    // Software clears IF while requesting; later ack is ignored.
    bus_write(16'hFF0F, 8'h00);
    step();
    check_irq("t4_drop", 1'b0, 16'h0000);
    ack = 1; step(); ack = 0; step();
    check_irq("t4_ack_ign", 1'b0, 16'h0000);
    bus_read("t4_if", 16'hFF0F, 8'hE0);
    bus_read("t4_ie", 16'hFFFF, 8'h08);

    // Edge beats a same-cycle IF write; held line sets IF only once.
    bus_write(16'hFFFF, 8'h04);
    addr = 16'hFF0F; tb_data = 8'h00; tb_drive = 1'b1; we_l = 1'b0; timer = 1;
    step();
    we_l = 1'b1; tb_drive = 1'b0;
    bus_read("t5_edge_wins", 16'hFF0F, 8'hE4);
    step();
    check_irq("t5_req", 1'b1, 16'h0050);
    ack = 1; step(); ack = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_irq("t5_held", 1'b0, 16'h0000);
    end
    bus_read("t5_if_once", 16'hFF0F, 8'hE0);
    timer = 0; step();

    // Reset during SERVICE with IF = 0x1F.
    bus_write(16'hFFFF, 8'h1F);
    vblank = 1; lcdc = 1; timer = 1; serial = 1; joypad = 1; step();
    vblank = 0; lcdc = 0; timer = 0; serial = 0; joypad = 0;
    step();
    check_irq("t6_req", 1'b1, 16'h0040);
    ack = 1; vblank = 1; step(); vblank = 0;
    bus_read("t6_if_svc", 16'hFF0F, 8'hFF);
    check_irq("t6_svc", 1'b0, 16'h0000);
    rst_l = 1'b0;
    #1;
    check_irq("t6_rst", 1'b0, 16'h0000);
    bus_read("t6_rst_if", 16'hFF0F, 8'hE0);
    bus_read("t6_rst_ie", 16'hFFFF, 8'h00);
    bus_read("t6_hiz", 16'hFF06, 8'h00);
    ack = 0;

    // Line already high when reset releases is captured at the first clock.
    joypad = 1;
    step();
    rst_l = 1'b1;
    step();
    bus_read("t7_rel_edge", 16'hFF0F, 8'hF0);
    joypad = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
